// File: rtl/vote_tally_seq.sv
// vote_tally_seq
// Serial election engine: collects NUM_VOTER one-hot ballots over a
// valid/ready handshake, counts them per candidate, scans the counters one
// candidate per cycle and then holds a one-hot winner with tie/no-winner
// flags and an invalid-ballot count until the next election is started.
module vote_tally_seq #(
    parameter int NUM_CAND  = 3,
    parameter int NUM_VOTER = 5,
    parameter int CNT_W     = $clog2(NUM_VOTER + 1),
    parameter int MAJORITY  = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                vote_valid,
    input  logic [NUM_CAND-1:0] vote,
    output logic                vote_ready,
    output logic                busy,
    output logic                done,
    output logic [NUM_CAND-1:0] winner,
    output logic                tie,
    output logic                no_winner,
    output logic [CNT_W-1:0]    invalid_cnt
);

    // Wide enough to count set ballot bits and to hold the scan index one
    // past the last candidate (the resolve step).
    localparam int IDX_W = $clog2(NUM_CAND + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DECIDE,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q [NUM_CAND];
    logic [CNT_W-1:0]    ballots_q;
    logic [CNT_W-1:0]    invalid_q;
    logic [CNT_W-1:0]    max_cnt_q;
    logic [IDX_W-1:0]    idx_q;
    logic [IDX_W-1:0]    max_idx_q;
    logic                dup_q;
    logic                vote_ready_q;
    logic                busy_q;
    logic                done_q;
    logic                tie_q;
    logic                no_winner_q;
    logic [NUM_CAND-1:0] winner_q;

    logic [IDX_W-1:0]    hot_cnt_d;
    logic                one_hot_d;
    logic [CNT_W-1:0]    scan_cnt_d;
    logic                valid_d;
    logic [NUM_CAND-1:0] winner_d;

    // Classify the presented ballot: valid only when exactly one bit is set.
    always_comb begin
        hot_cnt_d = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            hot_cnt_d = hot_cnt_d + IDX_W'(vote[i]);
        end
        one_hot_d = (hot_cnt_d == IDX_W'(1));
    end

    // Select the counter under the scan index; the resolve step reads zero.
    always_comb begin
        scan_cnt_d = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (idx_q == IDX_W'(i)) begin
                scan_cnt_d = cnt_q[i];
            end
        end
    end

    // Apply the election rule to the scanned maximum and build the winner.
    always_comb begin
        if (MAJORITY != 0) begin
            valid_d = ({max_cnt_q, 1'b0} > (CNT_W + 1)'(NUM_VOTER));
        end else begin
            valid_d = (max_cnt_q != '0) && !dup_q;
        end
        winner_d = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            winner_d[i] = valid_d && (max_idx_q == IDX_W'(i));
        end
    end

    // Election sequencer with its counters, scan registers and held results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            for (int i = 0; i < NUM_CAND; i++) begin
                cnt_q[i] <= '0;
            end
            ballots_q    <= '0;
            invalid_q    <= '0;
            max_cnt_q    <= '0;
            idx_q        <= '0;
            max_idx_q    <= '0;
            dup_q        <= 1'b0;
            vote_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            tie_q        <= 1'b0;
            no_winner_q  <= 1'b0;
            winner_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q      <= S_COLLECT;
                        for (int i = 0; i < NUM_CAND; i++) begin
                            cnt_q[i] <= '0;
                        end
                        ballots_q    <= '0;
                        invalid_q    <= '0;
                        max_cnt_q    <= '0;
                        idx_q        <= '0;
                        max_idx_q    <= '0;
                        dup_q        <= 1'b0;
                        vote_ready_q <= 1'b1;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        tie_q        <= 1'b0;
                        no_winner_q  <= 1'b0;
                        winner_q     <= '0;
                    end
                end
                S_COLLECT: begin
                    if (vote_valid) begin
                        if (one_hot_d) begin
                            for (int i = 0; i < NUM_CAND; i++) begin
                                if (vote[i]) begin
                                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                                end
                            end
                        end else begin
                            invalid_q <= invalid_q + CNT_W'(1);
                        end
                        ballots_q <= ballots_q + CNT_W'(1);
                        if (ballots_q == CNT_W'(NUM_VOTER - 1)) begin
                            state_q      <= S_DECIDE;
                            vote_ready_q <= 1'b0;
                            idx_q        <= '0;
                            max_cnt_q    <= '0;
                            max_idx_q    <= '0;
                            dup_q        <= 1'b0;
                        end
                    end
                end
                S_DECIDE: begin
                    if (idx_q < IDX_W'(NUM_CAND)) begin
                        if (scan_cnt_d > max_cnt_q) begin
                            max_cnt_q <= scan_cnt_d;
                            max_idx_q <= idx_q;
                            dup_q     <= 1'b0;
                        end else if ((scan_cnt_d == max_cnt_q) && (max_cnt_q != '0)) begin
                            dup_q     <= 1'b1;
                        end
                        idx_q <= idx_q + IDX_W'(1);
                    end else begin
                        state_q     <= S_DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        tie_q       <= dup_q;
                        no_winner_q <= !valid_d;
                        winner_q    <= winner_d;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign vote_ready  = vote_ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign winner      = winner_q;
    assign tie         = tie_q;
    assign no_winner   = no_winner_q;
    assign invalid_cnt = invalid_q;

endmodule
